// File: rtl/cu_control_decoder.sv
// Control-unit decoder: sequence state -> micro-ops, memory-read stall, retired-instruction count.
// Memory timeout watchdog and sticky bus_err are built only when CU_MEM_TIMEOUT_EN is defined.
module cu_control_decoder #(
  parameter int OPCODE_BITS = 2,
  parameter int N           = 4,
  parameter int TIMEOUT     = 15,
  parameter int CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           state,
  input  logic [OPCODE_BITS-1:0] dr_hi,
  input  logic                   mem_ready,
  output logic                   cnt_load,
  output logic                   cnt_inc,
  output logic                   cnt_clr,
  output logic [OPCODE_BITS-1:0] cnt_opcode,
  output logic                   mem_rd,
  output logic                   ar_ld_pc,
  output logic                   ar_ld_dr,
  output logic                   pc_inc,
  output logic                   pc_ld,
  output logic                   dr_ld,
  output logic                   ir_ld,
  output logic                   ac_ld,
  output logic                   ac_inc,
  output logic                   alu_sel,
  output logic                   bus_err,
  output logic [CNT_BITS-1:0]    instr_count
);

  localparam logic [N-1:0] S_FETCH1 = N'(0);
  localparam logic [N-1:0] S_FETCH2 = N'(1);
  localparam logic [N-1:0] S_FETCH3 = N'(2);
  localparam logic [N-1:0] S_ADD1   = N'(3);
  localparam logic [N-1:0] S_ADD2   = N'(4);
  localparam logic [N-1:0] S_AND1   = N'(5);
  localparam logic [N-1:0] S_AND2   = N'(6);
  localparam logic [N-1:0] S_JMP1   = N'(7);
  localparam logic [N-1:0] S_INC1   = N'(8);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic {HS_RUN = 1'b0, HS_WAIT = 1'b1} hs_state_t;

  hs_state_t             r_hs;
  hs_state_t             w_hs_nxt;
  logic                  w_err;
  logic                  w_mem_state;
  logic                  w_retire;
  logic [CNT_BITS-1:0]   r_instr_count;

  assign w_mem_state = (state == S_FETCH2) || (state == S_ADD1) || (state == S_AND1);

  // Decode; everything is forced low in reset and after a bus error so the CPU halts.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_opcode = '0;
    mem_rd     = 1'b0;
    ar_ld_pc   = 1'b0;
    ar_ld_dr   = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    dr_ld      = 1'b0;
    ir_ld      = 1'b0;
    ac_ld      = 1'b0;
    ac_inc     = 1'b0;
    alu_sel    = 1'b0;
    w_retire   = 1'b0;
    if (rst_n && !w_err) begin
      cnt_opcode = dr_hi;
      case (state)
        S_FETCH1: begin
          ar_ld_pc = 1'b1;
          cnt_inc  = 1'b1;
        end
        S_FETCH2: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld   = 1'b1;
            pc_inc  = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        S_FETCH3: begin
          ir_ld    = 1'b1;
          ar_ld_dr = 1'b1;
          cnt_load = 1'b1;
        end
        S_ADD1, S_AND1: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        S_ADD2: begin
          ac_ld    = 1'b1;
          cnt_clr  = 1'b1;
          w_retire = 1'b1;
        end
        S_AND2: begin
          ac_ld    = 1'b1;
          alu_sel  = 1'b1;
          cnt_clr  = 1'b1;
          w_retire = 1'b1;
        end
        S_JMP1: begin
          pc_ld    = 1'b1;
          cnt_clr  = 1'b1;
          w_retire = 1'b1;
        end
        S_INC1: begin
          ac_inc   = 1'b1;
          cnt_clr  = 1'b1;
          w_retire = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // WAIT needs no decode of its own: holding state is simply the absence of counter controls.
  always_comb begin
    w_hs_nxt = r_hs;
    case (r_hs)
      HS_RUN:  if (w_mem_state && !mem_ready && !w_err) w_hs_nxt = HS_WAIT;
      HS_WAIT: if (mem_ready || !w_mem_state || w_err) w_hs_nxt = HS_RUN;
      default: w_hs_nxt = HS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs          <= HS_RUN;
      r_instr_count <= '0;
    end else begin
      r_hs <= w_hs_nxt;
      if (w_retire) r_instr_count <= r_instr_count + 1'b1;
    end
  end

`ifdef CU_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_err;

  // A ready in the final allowed cycle completes the read instead of erroring.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else if (mem_rd && !mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) r_bus_err <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_err = r_bus_err;
`else
  assign w_err = 1'b0;
`endif

  assign bus_err     = rst_n & w_err;
  assign instr_count = rst_n ? r_instr_count : '0;

endmodule

// File: tb/tb_cu_control_decoder.sv
// Randomized bench for cu_control_decoder against a table-level behavioural model.
module tb_cu_control_decoder;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       load;
    logic       inc;
    logic       clr;
    logic [1:0] opc;
    logic       mem_rd;
    logic       ar_ld_pc;
    logic       ar_ld_dr;
    logic       pc_inc;
    logic       pc_ld;
    logic       dr_ld;
    logic       ir_ld;
    logic       ac_ld;
    logic       ac_inc;
    logic       alu_sel;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state = '0;
  logic [1:0]  dr_hi = '0;
  logic        mem_ready = 1'b1;
  logic        cnt_load, cnt_inc, cnt_clr, mem_rd, ar_ld_pc, ar_ld_dr, pc_inc, pc_ld;
  logic        dr_ld, ir_ld, ac_ld, ac_inc, alu_sel, bus_err;
  logic [1:0]  cnt_opcode;
  logic [15:0] instr_count;
  ctl_t        d_ctl;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt = 0;
  int   m_wait = 0;
  logic m_err = 1'b0;
  int   cs = 0;
  int   mrd;
  ctl_t lit;

  always #5 clk = ~clk;

  cu_control_decoder #(.OPCODE_BITS(2), .N(4), .TIMEOUT(TIMEOUT), .CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .dr_hi(dr_hi), .mem_ready(mem_ready),
    .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .cnt_opcode(cnt_opcode),
    .mem_rd(mem_rd), .ar_ld_pc(ar_ld_pc), .ar_ld_dr(ar_ld_dr), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .dr_ld(dr_ld), .ir_ld(ir_ld), .ac_ld(ac_ld), .ac_inc(ac_inc),
    .alu_sel(alu_sel), .bus_err(bus_err), .instr_count(instr_count)
  );

  assign d_ctl = {cnt_load, cnt_inc, cnt_clr, cnt_opcode, mem_rd, ar_ld_pc, ar_ld_dr,
                  pc_inc, pc_ld, dr_ld, ir_ld, ac_ld, ac_inc, alu_sel};

  // Expected controls straight from the action table.
  function automatic ctl_t model_ctl(int s, logic [1:0] op, logic rdy, logic err, logic rn);
    ctl_t c = '0;
    if (!rn || err) return c;
    c.opc = op;
    if (s == 1 || s == 3 || s == 5) begin
      c.mem_rd = 1'b1;
      if (rdy) begin
        c.dr_ld  = 1'b1;
        c.inc    = 1'b1;
        c.pc_inc = (s == 1);
      end
    end else if (s == 0) begin
      c.ar_ld_pc = 1'b1;
      c.inc      = 1'b1;
    end else if (s == 2) begin
      c.ir_ld    = 1'b1;
      c.ar_ld_dr = 1'b1;
      c.load     = 1'b1;
    end else begin
      c.clr     = 1'b1;
      c.ac_ld   = (s == 4 || s == 6);
      c.alu_sel = (s == 6);
      c.pc_ld   = (s == 7);
      c.ac_inc  = (s == 8);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state=%0d)", name, act, exp, $time, state);
    end
  endtask

  task automatic drive(input int s, input int op, input bit rdy, input bit rn);
    ctl_t e;
    state = s[3:0];
    dr_hi = op[1:0];
    mem_ready = rdy;
    rst_n = rn;
    @(negedge clk);
    e = model_ctl(s, op[1:0], rdy, m_err, rn);
    chk("model_ctl", d_ctl, e);
    chk("model_bus_err", bus_err, rn & m_err);
    chk("model_instr_count", instr_count, rn ? m_cnt : 0);
  endtask

  task automatic tick();
    ctl_t c;
    int s;
    s = state;
    c = model_ctl(s, dr_hi, mem_ready, m_err, rst_n);
    if (!rst_n) begin
      m_cnt = 0;
      m_wait = 0;
      m_err = 1'b0;
      cs = 0;
    end else begin
      if (c.clr && (s == 4 || s == 6 || s == 7 || s == 8)) m_cnt = (m_cnt + 1) % 65536;
`ifdef CU_MEM_TIMEOUT_EN
      if (c.mem_rd && !mem_ready) begin
        if (m_wait + 1 >= TIMEOUT) m_err = 1'b1;
        m_wait++;
      end else begin
        m_wait = 0;
      end
`endif
      if (c.load) cs = (dr_hi == 2'd0) ? 3 : (dr_hi == 2'd1) ? 5 : (dr_hi == 2'd2) ? 7 : 8;
      else if (c.inc) cs = cs + 1;
      else if (c.clr) cs = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int s, input int op, input bit rdy, input bit rn);
    drive(s, op, rdy, rn);
    tick();
  endtask

  initial begin
    drive(0, 0, 1, 0);
    chk("reset_ctl", d_ctl, 0);
    chk("reset_count", instr_count, 0);
    tick();
    cyc(0, 0, 1, 0);

    // ADD instruction, memory always ready
    drive(0, 0, 1, 1); chk("add_s0_cnt", {cnt_load, cnt_inc, cnt_clr}, 3'b010); tick();
    drive(1, 0, 1, 1); chk("add_s1_cnt", {cnt_load, cnt_inc, cnt_clr}, 3'b010); tick();
    drive(2, 0, 1, 1); chk("add_s2_cnt", {cnt_load, cnt_inc, cnt_clr}, 3'b100); tick();
    drive(3, 0, 1, 1); chk("add_s3_cnt", {cnt_load, cnt_inc, cnt_clr}, 3'b010); tick();
    drive(4, 0, 1, 1); chk("add_s4_cnt", {cnt_load, cnt_inc, cnt_clr}, 3'b001);
    chk("add_s4_alu", {ac_ld, alu_sel}, 2'b10); tick();
    chk("add_retire", instr_count, 1);

    // FETCH2 stall: three not-ready cycles then ready
    mrd = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, (i == 3), 1);
      mrd += int'(mem_rd);
      chk("stall_complete", {dr_ld, pc_inc, cnt_inc}, (i == 3) ? 3'b111 : 3'b000);
      tick();
    end
    chk("stall_mem_rd_cycles", mrd, 4);
    chk("stall_bus_err", bus_err, 0);

    // JMP
    drive(2, 2, 1, 1); chk("jmp_load", {cnt_load, cnt_opcode}, 3'b110); tick();
    drive(7, 2, 1, 1); chk("jmp_s7", {pc_ld, cnt_clr, cnt_inc, cnt_load}, 4'b1100); tick();
    chk("jmp_retire", instr_count, 2);

    // Illegal state
    lit = '0;
    lit.clr = 1'b1;
    drive(12, 0, 1, 1); chk("illegal_ctl", d_ctl, lit); tick();
    chk("illegal_no_retire", instr_count, 2);

    // Reset in the middle of a WAIT
    for (int i = 0; i < 5; i++) cyc(3, 0, 0, 1);
    drive(3, 0, 0, 0);
    chk("rst_wait_ctl", d_ctl, 0);
    chk("rst_wait_count", instr_count, 0);
    tick();
    drive(3, 0, 0, 1);
    chk("rst_release_count", instr_count, 0);
`ifdef CU_MEM_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i > 1) drive(3, 0, 0, 1);
      chk("timeout_pending", {mem_rd, bus_err}, 2'b10);
      tick();
    end
    drive(3, 0, 0, 1);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_halt", d_ctl, 0);
    tick();
    drive(1, 1, 1, 1);
    chk("timeout_sticky", {bus_err, d_ctl}, 16'h8000);
    tick();
`else
    tick();
    for (int i = 0; i < 120; i++) cyc(3, 0, 0, 1);
    drive(3, 0, 0, 1);
    chk("no_timeout_mem_rd", {mem_rd, bus_err}, 2'b10);
    tick();
`endif
    cyc(0, 0, 1, 0);

    // Closed loop with a bench sequence counter, mostly-ready memory
    for (int i = 0; i < 3000; i++)
      cyc(cs, $urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
    // Closed loop with slow memory to exercise long waits
    for (int i = 0; i < 3000; i++)
      cyc(cs, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) != 0));
    // Open loop: arbitrary state values including illegal ones
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 99) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
